// File: rtl/dff.sv
// dff: parameterizable D-type storage register with async active-low reset.
// Default parameters give a plain 1-bit flip-flop. STAGES > 1 turns it into
// a fixed-latency delay line where every stage resets to RESET_VALUE.
module dff #(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Reject illegal geometry at elaboration rather than building a broken register.
  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "dff: WIDTH must be >= 1");
  end
  if (STAGES < 1) begin : g_bad_stages
    $fatal(1, "dff: STAGES must be >= 1");
  end

  logic [WIDTH-1:0] r_stage [STAGES];

  // Shift chain: stage 0 captures d_i, later stages take the previous one.
  // Reset wins over a coincident clock edge because it is checked first.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      for (int k = 0; k < STAGES; k++) begin
        r_stage[k] <= RESET_VALUE;
      end
    end else begin
      r_stage[0] <= d_i;
      for (int k = 1; k < STAGES; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  // Output comes straight from the last register, no logic in between.
  assign q_o = r_stage[STAGES-1];

endmodule

// File: tb/tb_dff.sv
`timescale 1ns/1ps
module tb_dff;

  logic       clk;
  logic       rstb1;
  logic       d1;
  logic       q1;
  logic       rstb2;
  logic [7:0] d2;
  logic [7:0] q2;

  int n_checks = 0;
  int n_err    = 0;

  dff u_dut1 (
    .clock_i  (clk),
    .resetb_i (rstb1),
    .d_i      (d1),
    .q_o      (q1)
  );

  dff #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'hA5)) u_dut2 (
    .clock_i  (clk),
    .resetb_i (rstb2),
    .d_i      (d2),
    .q_o      (q2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_until(input longint t);
    if (t > $time) #(t - $time);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    rstb1 = 1'b0;
    d1    = 1'b0;
    rstb2 = 1'b0;
    d2    = 8'h00;

    // Reset hold with d toggling; edges 5..45 must be ignored.
    for (int i = 0; i < 5; i++) begin
      wait_until(i * 10);
      d1 = ~d1;
      d2 = d2 + 8'h11;
      wait_until(i * 10 + 7);
      chk("rst_hold_q1", {7'b0, q1}, 8'h00);
    end
    wait_until(48);
    chk("rst_hold_q2", q2, 8'hA5);

    // Release and capture.
    wait_until(50);
    rstb1 = 1'b1;
    d1    = 1'b0;
    wait_until(70);
    d1 = 1'b1;
    wait_until(72);
    chk("pre_capture", {7'b0, q1}, 8'h00);
    wait_until(76);
    chk("capture_1", {7'b0, q1}, 8'h01);

    // Follow data down.
    wait_until(120);
    d1 = 1'b0;
    wait_until(121);
    chk("hold_before_edge", {7'b0, q1}, 8'h01);
    wait_until(126);
    chk("follow_0", {7'b0, q1}, 8'h00);

    // Glitch between edges must not reach q.
    wait_until(127);
    d1 = 1'b1;
    wait_until(129);
    d1 = 1'b0;
    wait_until(136);
    chk("glitch_ignored", {7'b0, q1}, 8'h00);

    // Back to 1, then async reset between edges.
    wait_until(140);
    d1 = 1'b1;
    wait_until(146);
    chk("follow_1", {7'b0, q1}, 8'h01);
    wait_until(152);
    rstb1 = 1'b0;
    wait_until(153);
    chk("async_reset", {7'b0, q1}, 8'h00);
    wait_until(166);
    chk("reset_holds", {7'b0, q1}, 8'h00);

    // Release, get q to 0, then reset falling exactly on a clock edge with d=1.
    wait_until(170);
    rstb1 = 1'b1;
    wait_until(180);
    d1 = 1'b0;
    wait_until(186);
    chk("pre_edge_reset", {7'b0, q1}, 8'h00);
    wait_until(190);
    d1 = 1'b1;
    wait_until(195);
    rstb1 = 1'b0;
    wait_until(196);
    chk("reset_on_edge", {7'b0, q1}, 8'h00);

    // Delay line: release at 200; edges at 205,215,225,... .
    wait_until(199);
    chk("dl_in_reset", q2, 8'hA5);
    wait_until(200);
    rstb2 = 1'b1;
    d2    = 8'h3C;
    wait_until(206);
    chk("dl_edge1", q2, 8'hA5);
    wait_until(210);
    d2 = 8'h11;
    wait_until(216);
    chk("dl_edge2", q2, 8'hA5);
    wait_until(220);
    d2 = 8'h22;
    wait_until(226);
    chk("dl_edge3", q2, 8'h3C);
    wait_until(230);
    d2 = 8'h33;
    wait_until(236);
    chk("dl_edge4", q2, 8'h11);
    wait_until(246);
    chk("dl_edge5", q2, 8'h22);

    // Mid-stream reset discards in-flight data.
    wait_until(252);
    rstb2 = 1'b0;
    wait_until(253);
    chk("dl_async_reset", q2, 8'hA5);
    wait_until(260);
    rstb2 = 1'b1;
    d2    = 8'h44;
    wait_until(266);
    chk("dl_refill1", q2, 8'hA5);
    wait_until(276);
    chk("dl_refill2", q2, 8'hA5);
    wait_until(286);
    chk("dl_refill3", q2, 8'h44);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
